// File: rtl/gps_lut_arbiter_if.sv
// ---------------------------------------------------------------------------
// gps_lut_arbiter_if
//
// Purpose: bundles the requester, table-ROM and result signals of the
// shared GPS lookup-table controller into a single port.
//
// Signals:
//   req       requester -> arbiter   request per requester (bit0 cos, bit1 asin)
//   key0/key1 requester -> arbiter   search keys, sampled on grant
//   rom_en    arbiter   -> ROM       read enable
//   rom_addr  arbiter   -> ROM       read address
//   rom_data  ROM       -> arbiter   {x, y}, x in the MSBs, one cycle after rom_en
//   busy      arbiter   -> requester scan in progress
//   done      arbiter   -> requester one-cycle result strobe
//   done_id   arbiter   -> requester owner of the result (valid with done)
//   miss      arbiter   -> requester key outside the table range
//   x0/y0     arbiter   -> requester lower bracket entry
//   x1/y1     arbiter   -> requester upper bracket entry
//
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding datapath (requesters plus ROM model)
// ---------------------------------------------------------------------------
interface gps_lut_arbiter_if #(
    parameter int KEY_W  = 64,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 7
);
    logic [1:0]              req;
    logic [KEY_W-1:0]        key0;
    logic [KEY_W-1:0]        key1;
    logic                    rom_en;
    logic [ADDR_W-1:0]       rom_addr;
    logic [KEY_W+DATA_W-1:0] rom_data;
    logic                    busy;
    logic                    done;
    logic                    done_id;
    logic                    miss;
    logic [KEY_W-1:0]        x0;
    logic [KEY_W-1:0]        x1;
    logic [DATA_W-1:0]       y0;
    logic [DATA_W-1:0]       y1;

    modport slave (
        input  req, key0, key1, rom_data,
        output rom_en, rom_addr, busy, done, done_id, miss, x0, x1, y0, y1
    );

    modport master (
        output req, key0, key1, rom_data,
        input  rom_en, rom_addr, busy, done, done_id, miss, x0, x1, y0, y1
    );
endinterface

// File: rtl/gps_lut_arbiter.sv
// ---------------------------------------------------------------------------
// gps_lut_arbiter
//
// Purpose: owns the single synchronous table-ROM read port shared by the
// cosine (requester 0) and arcsine (requester 1) interpolators. A granted
// request scans the monotonic table from address 0 and returns the entry
// pair bracketing the key, so the requester can interpolate linearly.
//
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous, active-low reset
//   bus      slave modport of gps_lut_arbiter_if (requests, keys, ROM port,
//            busy/done/done_id/miss and bracket outputs x0,y0,x1,y1)
//
// Configuration macro:
//   LUT_ARB_FIXED_PRIO_EN  defined   -> fixed priority, requester 0 wins ties
//                          undefined -> round-robin, requester not granted
//                                       last wins ties (requester 0 first
//                                       after reset)
//
// Timing (grant edge E): address a is driven in cycle E+a, its entry is on
// rom_data in cycle E+a+1 and compared at edge E+a+2. A result found at
// entry k raises done k+2 clocks after the grant edge; no hit is DEPTH+1.
// ---------------------------------------------------------------------------
module gps_lut_arbiter #(
    parameter int KEY_W  = 64,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic                clk,
    input  logic                reset_n,
    gps_lut_arbiter_if.slave    bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Control state
    state_t              state_q,   state_d;
    logic                rom_en_q,  rom_en_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                done_id_q, done_id_d;
    logic                gnt_id_q,  gnt_id_d;

    // Result registers
    logic                miss_q,    miss_d;
    logic [KEY_W-1:0]    x0_q,      x0_d;
    logic [KEY_W-1:0]    x1_q,      x1_d;
    logic [DATA_W-1:0]   y0_q,      y0_d;
    logic [DATA_W-1:0]   y1_q,      y1_d;

    // Scan working registers (no reset needed: always written before use)
    logic [KEY_W-1:0]    key_q,     key_d;
    logic [KEY_W-1:0]    prev_x_q,  prev_x_d;
    logic [DATA_W-1:0]   prev_y_q,  prev_y_d;

    // ROM read pipeline: which address produced the word now on rom_data
    logic                vld_p1_q;
    logic [ADDR_W-1:0]   idx_p1_q;

    // Combinational helpers
    logic                gnt_c;
    logic                term_c;
    logic [KEY_W-1:0]    ent_x;
    logic [DATA_W-1:0]   ent_y;
    logic                ent_gt_key;
    logic                first_ent;

    assign ent_x      = bus.rom_data[KEY_W+DATA_W-1 -: KEY_W];
    assign ent_y      = bus.rom_data[DATA_W-1:0];
    assign ent_gt_key = (ent_x > key_q);
    assign first_ent  = (idx_p1_q == '0);

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
`ifdef LUT_ARB_FIXED_PRIO_EN
    // Requester 0 always wins; requester 1 only when it asks alone.
    always_comb begin
        gnt_c = ~bus.req[0];
    end
`else
    logic last_q, last_d;

    // On a tie the requester not granted last wins; otherwise the sole one.
    always_comb begin
        if (bus.req == 2'b11) begin
            gnt_c = ~last_q;
        end else begin
            gnt_c = bus.req[1];
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && bus.req != 2'b00) begin
            last_d = gnt_c;
        end
    end

    // Reset value 1 makes requester 0 the first winner of a tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Next-state / output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rom_en_d   = rom_en_q;
        rom_addr_d = rom_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        done_id_d  = done_id_q;
        gnt_id_d   = gnt_id_q;
        miss_d     = miss_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        key_d      = key_q;
        prev_x_d   = prev_x_q;
        prev_y_d   = prev_y_q;
        term_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    gnt_id_d   = gnt_c;
                    key_d      = gnt_c ? bus.key1 : bus.key0;
                    rom_addr_d = '0;
                    rom_en_d   = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = SCAN;
                end
            end

            SCAN: begin
                // Address runs ahead of the compare; it parks on the last entry.
                if (rom_addr_q != LAST_ADDR) begin
                    rom_addr_d = rom_addr_q + 1'b1;
                end

                if (vld_p1_q) begin
                    if (ent_gt_key) begin
                        // Entry 0 above the key means the key is below range.
                        term_c = 1'b1;
                        miss_d = first_ent;
                        x1_d   = ent_x;
                        y1_d   = ent_y;
                        x0_d   = first_ent ? ent_x : prev_x_q;
                        y0_d   = first_ent ? ent_y : prev_y_q;
                    end else if (idx_p1_q == LAST_ADDR) begin
                        // Key at or beyond the last x: clamp to the last entry.
                        term_c = 1'b1;
                        miss_d = 1'b1;
                        x0_d   = ent_x;
                        x1_d   = ent_x;
                        y0_d   = ent_y;
                        y1_d   = ent_y;
                    end else begin
                        // Not above the key yet: candidate lower bracket.
                        prev_x_d = ent_x;
                        prev_y_d = ent_y;
                    end
                end

                if (term_c) begin
                    done_d    = 1'b1;
                    done_id_d = gnt_id_q;
                    busy_d    = 1'b0;
                    rom_en_d  = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_id_q  <= 1'b0;
            gnt_id_q   <= 1'b0;
            miss_q     <= 1'b0;
            x0_q       <= '0;
            x1_q       <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            vld_p1_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            gnt_id_q   <= gnt_id_d;
            miss_q     <= miss_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            // ROM word is valid one cycle after an enabled read.
            vld_p1_q   <= rom_en_q;
        end
    end

    always_ff @(posedge clk) begin
        key_q    <= key_d;
        prev_x_q <= prev_x_d;
        prev_y_q <= prev_y_d;
        idx_p1_q <= rom_addr_q;
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.rom_en   = rom_en_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.done_id  = done_id_q;
    assign bus.miss     = miss_q;
    assign bus.x0       = x0_q;
    assign bus.x1       = x1_q;
    assign bus.y0       = y0_q;
    assign bus.y1       = y1_q;

endmodule

// File: tb/tb_gps_lut_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gps_lut_arbiter
//
// Self-checking bench for gps_lut_arbiter: directed vector table, random
// tables/keys against a bracket-search reference model, and hand-written
// sequences for tie arbitration and reset during a scan.
// ---------------------------------------------------------------------------
module tb_gps_lut_arbiter;

    localparam int KEY_W  = 64;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 128;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    gps_lut_arbiter_if #(.KEY_W(KEY_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    gps_lut_arbiter #(
        .KEY_W (KEY_W),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Synchronous table ROM
    logic [63:0] tbl_x [DEPTH];
    logic [63:0] tbl_y [DEPTH];

    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= {tbl_x[bus.rom_addr], tbl_y[bus.rom_addr]};
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] yf(input logic [63:0] x);
        return x * 3 + 7;
    endfunction

    task automatic load_linear(input logic [63:0] base);
        for (int i = 0; i < DEPTH; i++) begin
            tbl_x[i] = base + 64'(100 * i);
            tbl_y[i] = yf(tbl_x[i]);
        end
    endtask

    task automatic load_random(input logic [63:0] base);
        tbl_x[0] = base + 64'($urandom_range(1, 100));
        tbl_y[0] = {$urandom, $urandom};
        for (int i = 1; i < DEPTH; i++) begin
            tbl_x[i] = tbl_x[i-1] + 64'($urandom_range(1, 150));
            tbl_y[i] = {$urandom, $urandom};
        end
    endtask

    // Reference: first entry strictly above the key brackets it from above.
    task automatic ref_model(input logic [63:0] key,
                             output logic [63:0] ex0, output logic [63:0] ex1,
                             output logic [63:0] ey0, output logic [63:0] ey1,
                             output bit emiss, output int elat);
        int k = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (tbl_x[i] > key) begin
                k = i;
                break;
            end
        end
        if (k < 0) begin
            ex0 = tbl_x[DEPTH-1]; ex1 = tbl_x[DEPTH-1];
            ey0 = tbl_y[DEPTH-1]; ey1 = tbl_y[DEPTH-1];
            emiss = 1'b1; elat = DEPTH + 1;
        end else if (k == 0) begin
            ex0 = tbl_x[0]; ex1 = tbl_x[0];
            ey0 = tbl_y[0]; ey1 = tbl_y[0];
            emiss = 1'b1; elat = 2;
        end else begin
            ex0 = tbl_x[k-1]; ex1 = tbl_x[k];
            ey0 = tbl_y[k-1]; ey1 = tbl_y[k];
            emiss = 1'b0; elat = k + 2;
        end
    endtask

    // Issue one request, drop req right after the grant, wait for done.
    task automatic run_req(input bit id, input logic [63:0] key, output int lat);
        @(negedge clk);
        if (id) bus.key1 = key; else bus.key0 = key;
        bus.req = id ? 2'b10 : 2'b01;
        @(posedge clk);
        #1;
        bus.req = 2'b00;
        check("busy_after_grant", 64'(bus.busy), 64'd1);
        lat = -1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_result(input string tag, input bit id,
                                input logic [63:0] ex0, input logic [63:0] ex1,
                                input logic [63:0] ey0, input logic [63:0] ey1,
                                input bit emiss, input int elat, input int lat);
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        check({tag, "_done_id"}, 64'(bus.done_id), 64'(id));
        check({tag, "_miss"}, 64'(bus.miss), 64'(emiss));
        check({tag, "_x0"}, bus.x0, ex0);
        check({tag, "_x1"}, bus.x1, ex1);
        check({tag, "_y0"}, bus.y0, ey0);
        check({tag, "_y1"}, bus.y1, ey1);
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_x0_hold"}, bus.x0, ex0);
        check({tag, "_y1_hold"}, bus.y1, ey1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_en"},   64'(bus.rom_en),   64'd0);
        check({tag, "_rom_addr"}, 64'(bus.rom_addr), 64'd0);
        check({tag, "_busy"},     64'(bus.busy),     64'd0);
        check({tag, "_done"},     64'(bus.done),     64'd0);
        check({tag, "_done_id"},  64'(bus.done_id),  64'd0);
        check({tag, "_miss"},     64'(bus.miss),     64'd0);
        check({tag, "_x0"}, bus.x0, 64'd0);
        check({tag, "_x1"}, bus.x1, 64'd0);
        check({tag, "_y0"}, bus.y0, 64'd0);
        check({tag, "_y1"}, bus.y1, 64'd0);
    endtask

    typedef struct {
        logic [63:0] base;
        bit          id;
        logic [63:0] key;
        logic [63:0] x0;
        logic [63:0] x1;
        bit          miss;
        int          lat;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    initial begin
        // Watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        logic [63:0] ex0, ex1, ey0, ey1, key, cur_base;
        bit          emiss, id;
        int          elat;

        // Directed vectors on linear tables: {base, id, key, x0, x1, miss, latency}
        vecs[0] = '{64'd0,  1'b0, 64'd250,   64'd200,   64'd300,   1'b0, 5};
        vecs[1] = '{64'd0,  1'b1, 64'd300,   64'd300,   64'd400,   1'b0, 6};
        vecs[2] = '{64'd0,  1'b0, 64'd12800, 64'd12700, 64'd12700, 1'b1, DEPTH + 1};
        vecs[3] = '{64'd0,  1'b1, 64'd0,     64'd0,     64'd100,   1'b0, 3};
        vecs[4] = '{64'd0,  1'b0, 64'd12699, 64'd12600, 64'd12700, 1'b0, DEPTH + 1};
        vecs[5] = '{64'd0,  1'b1, 64'd12700, 64'd12700, 64'd12700, 1'b1, DEPTH + 1};
        vecs[6] = '{64'd50, 1'b0, 64'd10,    64'd50,    64'd50,    1'b1, 2};
        vecs[7] = '{64'd50, 1'b1, 64'd12850, 64'd12750, 64'd12750, 1'b1, DEPTH + 1};

        bus.req  = 2'b00;
        bus.key0 = '0;
        bus.key1 = '0;
        load_linear(64'd0);
        cur_base = 64'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Directed table
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].base != cur_base) begin
                load_linear(vecs[i].base);
                cur_base = vecs[i].base;
            end
            run_req(vecs[i].id, vecs[i].key, lat);
            check_result($sformatf("vec%0d", i), vecs[i].id, vecs[i].x0, vecs[i].x1,
                         yf(vecs[i].x0), yf(vecs[i].x1), vecs[i].miss, vecs[i].lat, lat);
        end

        // Random tables and keys against the reference model
        for (int t = 0; t < 40; t++) begin
            if (t % 10 == 0) load_random(((t / 10) % 2 == 1) ? 64'hF000_0000_0000_0000 : 64'd0);
            id = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: key = tbl_x[$urandom_range(0, DEPTH - 1)];
                1: key = tbl_x[0] - 64'd1;
                2: key = tbl_x[DEPTH-1] + 64'($urandom_range(0, 50));
                default: key = tbl_x[0] + 64'($urandom_range(0, 32'(tbl_x[DEPTH-1] - tbl_x[0])));
            endcase
            ref_model(key, ex0, ex1, ey0, ey1, emiss, elat);
            run_req(id, key, lat);
            check_result($sformatf("rnd%0d", t), id, ex0, ex1, ey0, ey1, emiss, elat, lat);
        end

        // Reset in the middle of a long scan
        load_linear(64'd0);
        @(negedge clk);
        bus.key0 = 64'd12800;
        bus.req  = 2'b01;
        @(posedge clk);
        #1;
        bus.req = 2'b00;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        check_reset_outputs("midscan_reset");
        @(negedge clk);
        reset_n = 1'b1;
        begin
            int ndone = 0;
            for (int n = 0; n < DEPTH + 20; n++) begin
                @(posedge clk);
                #1;
                if (bus.done) ndone++;
            end
            check("midscan_no_done", 64'(ndone), 64'd0);
            check("midscan_idle_busy", 64'(bus.busy), 64'd0);
        end
        run_req(1'b1, 64'd300, lat);
        check_result("after_reset", 1'b1, 64'd300, 64'd400, yf(64'd300), yf(64'd400), 1'b0, 6, lat);

        // Both requesters held continuously
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus.key0 = 64'd250;
        bus.key1 = 64'd300;
        bus.req  = 2'b11;
        begin
            int cyc = 0;
            int last_cyc = 0;
            int exp_id, exp_iv;
            bit got;
            for (int d = 0; d < 4; d++) begin
`ifdef LUT_ARB_FIXED_PRIO_EN
                exp_id = 0;
`else
                exp_id = d % 2;
`endif
                exp_iv = (exp_id == 0) ? 6 : 7;
                got = 1'b0;
                for (int n = 0; n < 300; n++) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                    if (bus.done) begin
                        got = 1'b1;
                        break;
                    end
                end
                check($sformatf("tie%0d_done_seen", d), 64'(got), 64'd1);
                check($sformatf("tie%0d_done_id", d), 64'(bus.done_id), 64'(exp_id));
                check($sformatf("tie%0d_interval", d), 64'(cyc - last_cyc), 64'(exp_iv));
                check($sformatf("tie%0d_x0", d), bus.x0, (exp_id == 0) ? 64'd200 : 64'd300);
                last_cyc = cyc;
                if (d == 3) bus.req = 2'b00;
            end
            repeat (3) @(posedge clk);
            #1;
            check("tie_end_busy", 64'(bus.busy), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
